// File: rtl/if_fetch_if.sv
// if_fetch_if: arbiter/ID-facing bus of the instruction-fetch stage.
interface if_fetch_if #(parameter int ADDR_W = 32);
   logic              if_request_o;
   logic [ADDR_W-1:0] if_addr_o;
   logic              if_grant_i;
   logic [7:0]        mem_din_i;
   logic              branch_i;
   logic [ADDR_W-1:0] branch_pc_i;
   logic              id_stall_i;
   logic              inst_valid_o;
   logic [31:0]       inst_o;
   logic [ADDR_W-1:0] inst_pc_o;
   modport master (
      output if_request_o, if_addr_o, inst_valid_o, inst_o, inst_pc_o,
      input  if_grant_i, mem_din_i, branch_i, branch_pc_i, id_stall_i
   );
   modport slave (
      input  if_request_o, if_addr_o, inst_valid_o, inst_o, inst_pc_o,
      output if_grant_i, mem_din_i, branch_i, branch_pc_i, id_stall_i
   );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetches four bytes per instruction through the arbiter and
// holds the assembled little-endian word until ID accepts it.
module if_fetch_unit #(
   parameter int                 ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input logic        clk,
   input logic        rst,
   input logic        rdy,
   if_fetch_if.master bus
);
   typedef enum logic {FETCH, HOLD} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, inst_pc_q, inst_pc_d;
   logic [2:0]        req_cnt_q, req_cnt_d, rcv_cnt_q, rcv_cnt_d;
   logic              pend_q, pend_d, inst_valid_q, inst_valid_d;
   logic [1:0]        pend_idx_q, pend_idx_d;
   logic [31:0]       asm_q, asm_d, inst_q, inst_d;
   logic              req, grant;
   assign req              = !rst && rdy && state_q == FETCH && req_cnt_q < 3'd4 && !bus.branch_i;
   assign grant            = req && bus.if_grant_i;
   assign bus.if_request_o = req;
   assign bus.if_addr_o    = rst ? '0 : pc_q + ADDR_W'(req_cnt_q);
   assign bus.inst_valid_o = inst_valid_q;
   assign bus.inst_o       = inst_q;
   assign bus.inst_pc_o    = inst_pc_q;
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_cnt_d    = req_cnt_q;
      rcv_cnt_d    = rcv_cnt_q;
      pend_d       = pend_q;
      pend_idx_d   = pend_idx_q;
      asm_d        = asm_q;
      inst_valid_d = inst_valid_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      if (rdy) begin
         if (bus.branch_i) begin
            state_d      = FETCH;
            pc_d         = bus.branch_pc_i;
            req_cnt_d    = '0;
            rcv_cnt_d    = '0;
            pend_d       = 1'b0;
            inst_valid_d = 1'b0;
         end else if (state_q == FETCH) begin
            // a grant in the capture cycle keeps the pipeline full
            pend_d = grant;
            if (grant) begin
               pend_idx_d = req_cnt_q[1:0];
               req_cnt_d  = req_cnt_q + 3'd1;
            end
            if (pend_q) begin
               asm_d[{pend_idx_q, 3'b000} +: 8] = bus.mem_din_i;
               rcv_cnt_d = rcv_cnt_q + 3'd1;
               if (rcv_cnt_q == 3'd3) begin
                  state_d      = HOLD;
                  inst_valid_d = 1'b1;
                  inst_d       = asm_d;
                  inst_pc_d    = pc_q;
               end
            end
         end else if (!bus.id_stall_i) begin
            state_d      = FETCH;
            pc_d         = pc_q + ADDR_W'(4);
            req_cnt_d    = '0;
            rcv_cnt_d    = '0;
            inst_valid_d = 1'b0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         req_cnt_q    <= '0;
         rcv_cnt_q    <= '0;
         pend_q       <= 1'b0;
         pend_idx_q   <= '0;
         asm_q        <= '0;
         inst_valid_q <= 1'b0;
         inst_q       <= '0;
         inst_pc_q    <= RESET_PC;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_cnt_q    <= req_cnt_d;
         rcv_cnt_q    <= rcv_cnt_d;
         pend_q       <= pend_d;
         pend_idx_q   <= pend_idx_d;
         asm_q        <= asm_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
      end
   end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenarios against a one-cycle-latency byte RAM
// and an arbiter that grants unless the MEM stage is marked busy.
module tb_if_fetch_unit;
   logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, busy = 1'b0;
   logic [7:0] mem_din = 8'h00;
   int errors = 0, checks = 0;
   if_fetch_if #(.ADDR_W(32)) bus ();
   if_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_byte = 8'h13;
         32'h0000_0001: mem_byte = 8'h05;
         32'h0000_0004: mem_byte = 8'h37;
         32'h0000_0005: mem_byte = 8'h01;
         32'h0000_0100: mem_byte = 8'h93;
         32'h0000_0102: mem_byte = 8'h10;
         32'hFFFF_FFFC: mem_byte = 8'h6f;
         default:       mem_byte = 8'h00;
      endcase
   endfunction
   assign bus.if_grant_i = bus.if_request_o & ~busy;
   assign bus.mem_din_i  = mem_din;
   always @(posedge clk) if (bus.if_grant_i) mem_din <= mem_byte(bus.if_addr_o);
   task automatic do_reset;
      rst = 1'b1; rdy = 1'b1; busy = 1'b0;
      bus.branch_i = 1'b0; bus.branch_pc_i = '0; bus.id_stall_i = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask
   task automatic test_reset;
      rst = 1'b1; rdy = 1'b1; busy = 1'b0;
      bus.branch_i = 1'b0; bus.branch_pc_i = 32'h55; bus.id_stall_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.if_request_o !== 1'b0 || bus.if_addr_o !== 32'h0 || bus.inst_valid_o !== 1'b0 ||
          bus.inst_o !== 32'h0 || bus.inst_pc_o !== 32'h0) begin
         errors++;
         $display("FAIL reset: req=%b addr=%h valid=%b inst=%h pc=%h, expected 0 0 0 0 0",
                  bus.if_request_o, bus.if_addr_o, bus.inst_valid_o, bus.inst_o, bus.inst_pc_o);
      end
   endtask
   task automatic test_basic;
      do_reset;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c <= 4) begin
            checks++;
            if (bus.if_request_o !== 1'b1 || bus.if_grant_i !== 1'b1 || bus.if_addr_o !== 32'(c - 1)) begin
               errors++;
               $display("FAIL basic_grant c%0d: req=%b grant=%b addr=%h, expected 1 1 %h",
                        c, bus.if_request_o, bus.if_grant_i, bus.if_addr_o, 32'(c - 1));
            end
         end
         if (c == 5) begin
            checks++;
            if (bus.inst_valid_o !== 1'b0) begin
               errors++; $display("FAIL basic_early_valid: got %b expected 0", bus.inst_valid_o);
            end
         end
         if (c == 6) begin
            checks++;
            if (bus.inst_valid_o !== 1'b1 || bus.inst_o !== 32'h0000_0513 || bus.inst_pc_o !== 32'h0) begin
               errors++;
               $display("FAIL basic_inst: valid=%b inst=%h pc=%h, expected 1 00000513 00000000",
                        bus.inst_valid_o, bus.inst_o, bus.inst_pc_o);
            end
         end
         @(posedge clk); #1;
      end
   endtask
   task automatic test_stall;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         checks++;
         if (bus.inst_valid_o !== 1'b1 || bus.inst_o !== 32'h0000_0513 || bus.inst_pc_o !== 32'h0 ||
             bus.if_request_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold c%0d: valid=%b inst=%h pc=%h req=%b, expected 1 00000513 00000000 0",
                     c, bus.inst_valid_o, bus.inst_o, bus.inst_pc_o, bus.if_request_o);
         end
         @(posedge clk); #1;
      end
      bus.id_stall_i = 1'b0;
      @(posedge clk); #1;
      bus.id_stall_i = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.if_request_o !== 1'b1 || bus.if_addr_o !== 32'h4 || bus.inst_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: req=%b addr=%h valid=%b, expected 1 00000004 0",
                  bus.if_request_o, bus.if_addr_o, bus.inst_valid_o);
      end
      @(posedge clk); #1;
   endtask
   task automatic test_grant_withheld;
      do_reset;
      for (int c = 1; c <= 9; c++) begin
         busy = (c >= 2 && c <= 4);
         @(negedge clk);
         if (c >= 2 && c <= 4) begin
            checks++;
            if (bus.if_request_o !== 1'b1 || bus.if_grant_i !== 1'b0 || bus.if_addr_o !== 32'h1) begin
               errors++;
               $display("FAIL withheld_addr c%0d: req=%b grant=%b addr=%h, expected 1 0 00000001",
                        c, bus.if_request_o, bus.if_grant_i, bus.if_addr_o);
            end
         end
         if (c == 8) begin
            checks++;
            if (bus.inst_valid_o !== 1'b0) begin
               errors++; $display("FAIL withheld_early_valid: got %b expected 0", bus.inst_valid_o);
            end
         end
         if (c == 9) begin
            checks++;
            if (bus.inst_valid_o !== 1'b1 || bus.inst_o !== 32'h0000_0513) begin
               errors++;
               $display("FAIL withheld_inst: valid=%b inst=%h, expected 1 00000513", bus.inst_valid_o, bus.inst_o);
            end
         end
         @(posedge clk); #1;
      end
      busy = 1'b0;
   endtask
   task automatic test_branch;
      do_reset;
      for (int c = 1; c <= 10; c++) begin
         bus.branch_i    = (c == 3 || c == 10);
         bus.branch_pc_i = (c == 10) ? 32'h200 : 32'h100;
         bus.id_stall_i  = (c != 10);
         @(negedge clk);
         if (c == 3) begin
            checks++;
            if (bus.if_request_o !== 1'b0) begin
               errors++; $display("FAIL branch_cycle_req: got %b expected 0", bus.if_request_o);
            end
         end
         if (c == 4) begin
            checks++;
            if (bus.if_request_o !== 1'b1 || bus.if_addr_o !== 32'h100) begin
               errors++;
               $display("FAIL branch_target: req=%b addr=%h, expected 1 00000100", bus.if_request_o, bus.if_addr_o);
            end
         end
         if (c == 8) begin
            checks++;
            if (bus.inst_valid_o !== 1'b0) begin
               errors++; $display("FAIL branch_early_valid: got %b expected 0", bus.inst_valid_o);
            end
         end
         if (c == 9) begin
            checks++;
            if (bus.inst_valid_o !== 1'b1 || bus.inst_o !== 32'h0010_0093 || bus.inst_pc_o !== 32'h100) begin
               errors++;
               $display("FAIL branch_inst: valid=%b inst=%h pc=%h, expected 1 00100093 00000100",
                        bus.inst_valid_o, bus.inst_o, bus.inst_pc_o);
            end
         end
         @(posedge clk); #1;
      end
      bus.branch_i = 1'b0; bus.id_stall_i = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.if_request_o !== 1'b1 || bus.if_addr_o !== 32'h200 || bus.inst_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL branch_vs_accept: req=%b addr=%h valid=%b, expected 1 00000200 0",
                  bus.if_request_o, bus.if_addr_o, bus.inst_valid_o);
      end
      @(posedge clk); #1;
   endtask
   task automatic test_rdy;
      do_reset;
      for (int c = 1; c <= 9; c++) begin
         rdy = !(c >= 3 && c <= 5);
         @(negedge clk);
         if (c >= 3 && c <= 5) begin
            checks++;
            if (bus.if_request_o !== 1'b0 || bus.if_addr_o !== 32'h2) begin
               errors++;
               $display("FAIL rdy_freeze c%0d: req=%b addr=%h, expected 0 00000002", c, bus.if_request_o, bus.if_addr_o);
            end
         end
         if (c == 6) begin
            checks++;
            if (bus.if_request_o !== 1'b1 || bus.if_addr_o !== 32'h2) begin
               errors++;
               $display("FAIL rdy_resume: req=%b addr=%h, expected 1 00000002", bus.if_request_o, bus.if_addr_o);
            end
         end
         if (c == 8) begin
            checks++;
            if (bus.inst_valid_o !== 1'b0) begin
               errors++; $display("FAIL rdy_early_valid: got %b expected 0", bus.inst_valid_o);
            end
         end
         if (c == 9) begin
            checks++;
            if (bus.inst_valid_o !== 1'b1 || bus.inst_o !== 32'h0000_0513 || bus.inst_pc_o !== 32'h0) begin
               errors++;
               $display("FAIL rdy_inst: valid=%b inst=%h pc=%h, expected 1 00000513 00000000",
                        bus.inst_valid_o, bus.inst_o, bus.inst_pc_o);
            end
         end
         @(posedge clk); #1;
      end
      rdy = 1'b1;
   endtask
   task automatic test_wrap;
      do_reset;
      for (int c = 1; c <= 8; c++) begin
         bus.branch_i    = (c == 1);
         bus.branch_pc_i = 32'hFFFF_FFFC;
         bus.id_stall_i  = (c != 8);
         @(negedge clk);
         if (c == 2 || c == 5) begin
            checks++;
            if (bus.if_request_o !== 1'b1 || bus.if_addr_o !== ((c == 2) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF)) begin
               errors++;
               $display("FAIL wrap_addr c%0d: req=%b addr=%h", c, bus.if_request_o, bus.if_addr_o);
            end
         end
         if (c == 7) begin
            checks++;
            if (bus.inst_valid_o !== 1'b1 || bus.inst_o !== 32'h0000_006f || bus.inst_pc_o !== 32'hFFFF_FFFC) begin
               errors++;
               $display("FAIL wrap_inst: valid=%b inst=%h pc=%h, expected 1 0000006f fffffffc",
                        bus.inst_valid_o, bus.inst_o, bus.inst_pc_o);
            end
         end
         @(posedge clk); #1;
      end
      bus.branch_i = 1'b0; bus.id_stall_i = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.if_request_o !== 1'b1 || bus.if_addr_o !== 32'h0) begin
         errors++;
         $display("FAIL wrap_next: req=%b addr=%h, expected 1 00000000", bus.if_request_o, bus.if_addr_o);
      end
      @(posedge clk); #1;
   endtask
   initial begin
      bus.branch_i = 1'b0; bus.branch_pc_i = '0; bus.id_stall_i = 1'b1;
      test_reset;
      test_basic;
      test_stall;
      test_grant_withheld;
      test_branch;
      test_rdy;
      test_wrap;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
